// File: rtl/cpu_cycle_sched_m.sv
// cpu_cycle_sched_m: CPU phi2 generator choosing fast 4 MHz cycles or host-aligned stretched cycles
module cpu_cycle_sched_m #(
    parameter int WAIT_CNT_W = 8
) (
    input  logic                  bbc_ck8,
    input  logic                  resetb,
    input  logic                  bbc_phi0,
    input  logic                  bbc_1mhze,
    input  logic                  hs_en,
    input  logic                  acc_valid,
    input  logic                  acc_host,
    input  logic                  acc_1mhz,
    input  logic                  wait_cnt_clr,
    output logic                  cpu_phi2,
    output logic                  host_cycle,
    output logic                  data_latch_en,
    output logic [WAIT_CNT_W-1:0] wait_cnt
);
    typedef enum logic [3:0] {
        PH1       = 4'b0001,
        FAST_PH2  = 4'b0010,
        HOST_WAIT = 4'b0100,
        HOST_PH2  = 4'b1000
    } state_t;
    state_t     state, nxt;
    logic       phi0_q;
    logic [1:0] hph;
    logic       hr, hn;
    assign hr = (hph == 2'd1) & (~acc_1mhz | bbc_1mhze);
    assign hn = ~hs_en | (acc_valid & acc_host);
    always_comb begin
        nxt = state == PH1       ? (hn ? (hr ? HOST_PH2 : HOST_WAIT) : FAST_PH2) :
              state == HOST_WAIT ? (hr ? HOST_PH2 : HOST_WAIT) :
              state == HOST_PH2  ? (hph == 2'd3 ? PH1 : HOST_PH2) : PH1;
    end
    always_ff @(posedge bbc_ck8 or negedge resetb) begin
        if (!resetb) begin
            phi0_q   <= 1'b0;
            hph      <= 2'd0;
            state    <= PH1;
            cpu_phi2 <= 1'b0;
            wait_cnt <= '0;
        end else begin
            phi0_q   <= bbc_phi0;
            hph      <= (phi0_q & ~bbc_phi0) ? 2'd0 : hph + 2'd1;
            state    <= nxt;
            cpu_phi2 <= (nxt == FAST_PH2) | (nxt == HOST_PH2);
            wait_cnt <= wait_cnt_clr ? '0 :
                        (nxt == HOST_WAIT && wait_cnt != '1) ? wait_cnt + 1'b1 : wait_cnt;
        end
    end
    assign host_cycle    = state == HOST_PH2;
    assign data_latch_en = host_cycle & (hph == 2'd3);
endmodule

// File: tb/tb_cpu_cycle_sched_m.sv
// tb_cpu_cycle_sched_m: randomized and directed bench for cpu_cycle_sched_m against a cycle model
module tb_cpu_cycle_sched_m;
    logic       bbc_ck8 = 1'b0, resetb = 1'b0, bbc_phi0 = 1'b0, bbc_1mhze = 1'b0;
    logic       hs_en = 1'b0, acc_valid = 1'b0, acc_host = 1'b0, acc_1mhz = 1'b0, wait_cnt_clr = 1'b0;
    logic       cpu_phi2, host_cycle, data_latch_en;
    logic [7:0] wait_cnt;
    int checks = 0, errors = 0, hcnt = 0;
    int m_st = 0, m_hph = 0, m_cnt = 0;
    bit m_phi0q = 1'b0;
    localparam int S_PH1 = 0, S_FAST = 1, S_WAIT = 2, S_HOST = 3;

    always #5 bbc_ck8 = ~bbc_ck8;

    cpu_cycle_sched_m #(.WAIT_CNT_W(8)) dut (
        .bbc_ck8(bbc_ck8), .resetb(resetb), .bbc_phi0(bbc_phi0), .bbc_1mhze(bbc_1mhze),
        .hs_en(hs_en), .acc_valid(acc_valid), .acc_host(acc_host), .acc_1mhz(acc_1mhz),
        .wait_cnt_clr(wait_cnt_clr), .cpu_phi2(cpu_phi2), .host_cycle(host_cycle),
        .data_latch_en(data_latch_en), .wait_cnt(wait_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_PH1; m_hph = 0; m_cnt = 0; m_phi0q = 1'b0;
    endtask

    // One host ck: drive phi0 from the host phase, compare at negedge, advance model at posedge.
    task automatic tick();
        int n;
        bit hr, hn;
        bbc_phi0 = (hcnt >= 2);
        @(negedge bbc_ck8);
        chk("cpu_phi2", cpu_phi2, int'(m_st == S_FAST || m_st == S_HOST));
        chk("host_cycle", host_cycle, int'(m_st == S_HOST));
        chk("data_latch_en", data_latch_en, int'(m_st == S_HOST && m_hph == 3));
        chk("wait_cnt", wait_cnt, m_cnt);
        hr = (m_hph == 1) && (!acc_1mhz || bbc_1mhze);
        hn = !hs_en || (acc_valid && acc_host);
        case (m_st)
            S_PH1:   n = hn ? (hr ? S_HOST : S_WAIT) : S_FAST;
            S_FAST:  n = S_PH1;
            S_WAIT:  n = hr ? S_HOST : S_WAIT;
            default: n = (m_hph == 3) ? S_PH1 : S_HOST;
        endcase
        @(posedge bbc_ck8);
        if (!resetb) model_reset();
        else begin
            m_cnt   = wait_cnt_clr ? 0 : (n == S_WAIT && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            m_hph   = (m_phi0q && !bbc_phi0) ? 0 : (m_hph + 1) % 4;
            m_phi0q = bbc_phi0;
            m_st    = n;
        end
        #1;
        hcnt = (hcnt + 1) % 4;
    endtask

    task automatic wait_for(input int st, input int hph, input string tag);
        int k = 0;
        while (k < 40 && !(m_st == st && (hph < 0 || m_hph == hph))) begin
            tick();
            k++;
        end
        chk({"reach_", tag}, int'(k < 40), 1);
    endtask

    initial begin
        int rises, lats, hosts, c0, k, bad, fall_ck, lat_ck;
        bit prev;
        model_reset();
        repeat (3) tick();
        resetb = 1'b1;
        // slow mode: one 4-ck cycle per host cycle, one wait ck each
        repeat (8) tick();
        rises = 0; lats = 0; c0 = int'(wait_cnt); prev = cpu_phi2;
        repeat (16) begin
            tick();
            if (cpu_phi2 && !prev) rises++;
            prev = cpu_phi2;
            lats += int'(data_latch_en);
        end
        chk("slow_rises", rises, 4);
        chk("slow_latch", lats, 4);
        chk("slow_wait", int'(wait_cnt) - c0, 4);
        // fast mode
        wait_for(S_HOST, -1, "slow_host");
        hs_en = 1'b1; acc_valid = 1'b1; acc_host = 1'b0; wait_cnt_clr = 1'b1;
        repeat (4) tick();
        wait_cnt_clr = 1'b0;
        wait_for(S_PH1, -1, "fast_ph1");
        rises = 0; hosts = 0; prev = cpu_phi2;
        repeat (20) begin
            tick();
            if (cpu_phi2 && !prev) rises++;
            prev = cpu_phi2;
            hosts += int'(host_cycle);
        end
        chk("fast_cycles", rises, 10);
        chk("fast_host", hosts, 0);
        chk("fast_wait", wait_cnt, 0);
        // host access whose PH1 lands at hph2
        wait_for(S_FAST, 1, "fast_hph1");
        acc_host = 1'b1;
        tick();
        k = 0;
        while (!host_cycle && k < 10) begin
            tick();
            k++;
        end
        chk("wait3_lat", k, 4);
        chk("wait3_cnt", wait_cnt, 3);
        acc_host = 1'b0;
        repeat (6) tick();
        // endless 1 MHz stretch saturates the counter
        wait_for(S_FAST, -1, "sat_fast");
        acc_host = 1'b1; acc_1mhz = 1'b1; bbc_1mhze = 1'b0;
        repeat (300) tick();
        chk("sat", wait_cnt, 255);
        chk("sat_host", host_cycle, 0);
        wait_cnt_clr = 1'b1;
        tick();
        wait_cnt_clr = 1'b0;
        chk("clr", wait_cnt, 0);
        // open the 1 MHz window; host phi2 only while bbc_1mhze is high
        k = 0;
        while (hcnt != 0 && k < 4) begin tick(); k++; end
        bbc_1mhze = 1'b1;
        bad = 0; k = 0;
        while (!host_cycle && k < 8) begin tick(); k++; end
        chk("1mhz_seen", int'(host_cycle), 1);
        acc_host = 1'b0; acc_1mhz = 1'b0;
        repeat (8) begin
            if (hcnt == 0) bbc_1mhze = ~bbc_1mhze;
            tick();
            if (host_cycle && !bbc_1mhze) bad++;
        end
        chk("1mhz_win", bad, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (m_st == S_FAST || m_st == S_HOST) begin
                acc_valid = ($urandom % 4) != 0;
                acc_host  = ($urandom % 3) == 0;
                acc_1mhz  = ($urandom % 4) == 0;
                hs_en     = ($urandom % 8) != 0;
            end
            if (hcnt == 0) bbc_1mhze = $urandom % 2;
            wait_cnt_clr = ($urandom % 16) == 0;
            tick();
        end
        wait_cnt_clr = 1'b0;
        // reset during HOST_PH2, release with bbc_phi0 high
        wait_for(S_FAST, -1, "pre_rst");
        hs_en = 1'b0; acc_1mhz = 1'b0;
        wait_for(S_HOST, 2, "rst_host");
        resetb = 1'b0;
        #1;
        chk("rst_cpu", cpu_phi2, 0);
        chk("rst_hc", host_cycle, 0);
        chk("rst_cnt", wait_cnt, 0);
        model_reset();
        repeat (2) tick();
        k = 0;
        while (hcnt != 2 && k < 4) begin tick(); k++; end
        resetb = 1'b1;
        fall_ck = -1; lat_ck = -1; prev = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (prev && !bbc_phi0 && fall_ck < 0) fall_ck = j;
            prev = bbc_phi0;
            if (data_latch_en && lat_ck < 0) lat_ck = j + 1;
        end
        chk("relock_seen", int'(fall_ck >= 0 && lat_ck >= 0), 1);
        chk("relock_gap", int'(lat_ck >= fall_ck + 3), 1);
        repeat (8) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
